// File: rtl/unified_mem_arbiter.sv
// Arbiter for the shared instruction/data memory: CPU priority with a DMA starvation limit,
// each access sequenced IDLE -> BUSY (MEM_LAT cycles) -> RESP (one-cycle ack).
`timescale 1ns/1ps
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_ack,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_addr,
  input  logic [DATA_W-1:0] i_dma_wdata,
  output logic [DATA_W-1:0] o_dma_rdata,
  output logic              o_dma_ack,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_grant_dma
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [3:0]        r_starve;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic w_any_req;
  logic w_dma_win;

  assign w_any_req = i_cpu_req | i_dma_req;
  // DMA wins when alone, or when the CPU has won STARVE_LIM contested rounds in a row
  assign w_dma_win = i_dma_req & (~i_cpu_req | (r_starve == STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state <= S_BUSY;
            r_cnt   <= LAT_M1;
            r_owner <= w_dma_win;
            r_we    <= w_dma_win ? i_dma_we    : i_cpu_we;
            r_addr  <= w_dma_win ? i_dma_addr  : i_cpu_addr;
            r_wdata <= w_dma_win ? i_dma_wdata : i_cpu_wdata;
            if (w_dma_win)
              r_starve <= '0;
            else if (i_dma_req && (r_starve != STARVE_MAX))
              r_starve <= r_starve + 4'd1;
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            if (!r_we) begin
              if (r_owner) r_dma_rdata <= i_mem_rdata;
              else         r_cpu_rdata <= i_mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_en    = (r_state == S_BUSY);
  assign o_mem_we    = (r_state == S_BUSY) & r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_grant_dma = (r_state != S_IDLE) & r_owner;
  assign o_cpu_ack   = (r_state == S_RESP) & ~r_owner;
  assign o_dma_ack   = (r_state == S_RESP) & r_owner;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: a table of single-port transactions plus hand-written sequences for
// starvation, mid-BUSY input changes, reset abort and a MEM_LAT=1 build.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_en, mem_we, grant_dma;

  logic        c1_req;
  logic [31:0] c1_addr, c1_rdata, d1_dma_rdata, d1_mem_addr, d1_mem_wdata, mem1_rdata;
  logic        c1_ack, d1_dma_ack, d1_mem_en, d1_mem_we, d1_grant;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_LIM(2)) dut (
    .clk(clk), .rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_rdata(dma_rdata), .o_dma_ack(dma_ack),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_grant_dma(grant_dma)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIM(3)) dut1 (
    .clk(clk), .rst(rst),
    .i_cpu_req(c1_req), .i_cpu_we(1'b0), .i_cpu_addr(c1_addr), .i_cpu_wdata(32'h0),
    .o_cpu_rdata(c1_rdata), .o_cpu_ack(c1_ack),
    .i_dma_req(1'b0), .i_dma_we(1'b0), .i_dma_addr(32'h0), .i_dma_wdata(32'h0),
    .o_dma_rdata(d1_dma_rdata), .o_dma_ack(d1_dma_ack),
    .o_mem_en(d1_mem_en), .o_mem_we(d1_mem_we), .o_mem_addr(d1_mem_addr), .o_mem_wdata(d1_mem_wdata),
    .i_mem_rdata(mem1_rdata), .o_grant_dma(d1_grant)
  );

  // word-addressed memory behind the main instance; the second instance sees a fixed pattern
  logic [31:0] mem [0:255];
  assign mem_rdata  = mem[mem_addr[9:2]];
  assign mem1_rdata = d1_mem_addr ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[4] <= 32'hDEAD_BEEF;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        is_dma;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_cpu;
    logic [31:0] exp_dma;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one transaction on the main instance, checking bus behaviour and latency on the way
  task automatic txn(input logic is_dma, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input string tag);
    int  cyc;
    int  en_cyc;
    logic got;
    @(negedge clk);
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    cyc = 0; en_cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_en) begin
        en_cyc++;
        chk({tag, "_addr"}, mem_addr, addr);
        chk({tag, "_we"}, {31'b0, mem_we}, {31'b0, we});
        chk({tag, "_grant"}, {31'b0, grant_dma}, {31'b0, is_dma});
        if (we) chk({tag, "_wdata"}, mem_wdata, wdata);
      end
      chk({tag, "_other_ack"}, {31'b0, (is_dma ? cpu_ack : dma_ack)}, 32'h0);
      got = is_dma ? dma_ack : cpu_ack;
    end
    chk({tag, "_acked"}, {31'b0, got}, 32'h1);
    chk({tag, "_latency"}, 32'(cyc), 32'd3);
    chk({tag, "_busy_len"}, 32'(en_cyc), 32'd2);
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  initial begin
    int          n;
    int          cyc;
    int          acks;
    int          last_ack;
    logic [5:0]  order;
    logic [31:0] a1;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h40, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h40, 32'h0,         32'h1234_5678, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h1234_5678, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b1, 32'h10, 32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'hCAFE_F00D, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 1'b0, 32'h44, 32'h0,         32'hCAFE_F00D, 32'h1000_0011};

    rst = 1'b1; preload = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    c1_req = 0; c1_addr = 0;

    repeat (2) @(negedge clk);
    chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_acks", {30'b0, cpu_ack, dma_ack}, 32'h0);
    chk("rst_grant", {31'b0, grant_dma}, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_dma_rdata", dma_rdata, 32'h0);
    rst = 1'b0; preload = 1'b0;

    for (int i = 0; i < 7; i++) begin
      txn(vecs[i].is_dma, vecs[i].we, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vecs[i].exp_cpu);
      chk($sformatf("vec%0d_dma_rdata", i), dma_rdata, vecs[i].exp_dma);
    end

    // both ports held high: with STARVE_LIM=2 the order is C C D C C D
    order = 6'b100100;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dma_req = 1; dma_we = 0; dma_addr = 32'h44;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack || dma_ack) begin
        chk($sformatf("starve_one_ack%0d", n), {31'b0, cpu_ack & dma_ack}, 32'h0);
        chk($sformatf("starve_order%0d", n), {31'b0, dma_ack}, {31'b0, order[n]});
        n++;
      end
    end
    chk("starve_ack_count", 32'(n), 32'd6);
    cpu_req = 0; dma_req = 0;

    // requester address changes mid-BUSY must not reach the memory
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk);
    chk("hold_busy1_addr", mem_addr, 32'h10);
    cpu_addr = 32'h20;
    @(negedge clk);
    chk("hold_busy2_en", {31'b0, mem_en}, 32'h1);
    chk("hold_busy2_addr", mem_addr, 32'h10);
    @(negedge clk);
    chk("hold_ack", {31'b0, cpu_ack}, 32'h1);
    chk("hold_rdata", cpu_rdata, 32'hCAFE_F00D);
    cpu_req = 0;

    // reset in the first BUSY cycle of a write
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'h55AA_55AA;
    @(negedge clk);
    chk("abort_busy_en", {30'b0, mem_en, mem_we}, 32'h3);
    #1 rst = 1'b1;
    #1;
    chk("abort_en_drop", {31'b0, mem_en}, 32'h0);
    chk("abort_we_drop", {31'b0, mem_we}, 32'h0);
    cpu_req = 0; cpu_we = 0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_ack", {31'b0, cpu_ack}, 32'h0);
    end
    chk("abort_cpu_rdata", cpu_rdata, 32'h0);
    rst = 1'b0;
    txn(1'b0, 1'b0, 32'h14, 32'h0, "post_rst");
    chk("post_rst_rdata", cpu_rdata, 32'h1000_0005);

    // MEM_LAT=1 instance: ack 2 cycles after sampling, then one access every 3 cycles
    @(negedge clk);
    a1 = 32'h100;
    c1_req = 1; c1_addr = a1;
    acks = 0; cyc = 0; last_ack = 0;
    while (acks < 3 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (c1_ack) begin
        chk($sformatf("lat1_rdata%0d", acks), c1_rdata, a1 ^ 32'hA5A5_0000);
        if (acks == 0) chk("lat1_first_latency", 32'(cyc), 32'd2);
        else           chk($sformatf("lat1_interval%0d", acks), 32'(cyc - last_ack), 32'd3);
        last_ack = cyc;
        acks++;
        a1 = a1 + 32'h4;
        c1_addr = a1;
      end
    end
    chk("lat1_ack_count", 32'(acks), 32'd3);
    c1_req = 0;

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
